instr_prefetch_queue: RTL and testbench

Instruction fetch front end for the RISC-V core. It issues sequential word fetches to instruction memory over a request/grant/response handshake and buffers returned instructions, with their PC and PC+4, in a small FIFO. Decode consumes the FIFO through a valid/ready port. Taken branches, `jal` and `jalr` flush the queue and restart fetch through `redirect`/`redirect_pc`, driven by the PC_src/ALU-result path.

---
 rtl/instr_prefetch_queue.sv | 101 ++++++++++
 tb/tb_instr_prefetch_queue.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction fetch front end: single-outstanding sequential word fetcher
// feeding a small {instr, pc} FIFO, with flush/refetch on redirect.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_pc_4,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   fetch_pc;
  logic [31:0]   pending_pc;
  logic          outstanding;
  logic          discard;

  logic          granted;
  logic          rsp;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_pc_al;

  // Handshake decode; redirect masks issue and the output port in its own cycle
  always_comb begin
    redirect_pc_al = redirect_pc & ~32'h3;
    imem_req       = rst && !outstanding && (count < CW'(DEPTH)) && !redirect;
    out_valid      = (count != '0) && !redirect;
    granted        = imem_req && imem_gnt;
    rsp            = imem_rvalid && outstanding;
    push           = rsp && !discard && !redirect;
    pop            = out_valid && out_ready;
  end

  assign imem_addr = fetch_pc;
  assign out_instr = instr_q[rd_ptr];
  assign out_pc    = pc_q[rd_ptr];
  assign out_pc_4  = pc_q[rd_ptr] + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      pending_pc  <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (redirect) begin
      // A response landing in the redirect cycle retires the pending request
      fetch_pc    <= redirect_pc_al;
      outstanding <= outstanding && !imem_rvalid;
      discard     <= outstanding && !imem_rvalid;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      if (rsp) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end
      if (granted) begin
        outstanding <= 1'b1;
        pending_pc  <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (push) begin
        instr_q[wr_ptr] <= imem_rdata;
        pc_q[wr_ptr]    <= pending_pc;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed per-cycle vector bench for instr_prefetch_queue (DEPTH=4).
module tb_instr_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_4;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_4(out_pc_4), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [2:0]  e_count;
  } vec_t;

  localparam int NV = 28;
  vec_t vt [NV];

  function automatic vec_t mk(logic redir, logic [31:0] rpc, logic gnt, logic rvalid,
                              logic [31:0] rdata, logic ready, logic e_req,
                              logic [31:0] e_addr, logic e_valid, logic [31:0] e_pc,
                              logic [31:0] e_instr, logic [2:0] e_count);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata;
    v.ready = ready; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_count = e_count;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic redir, input logic [31:0] rpc, input logic gnt,
                       input logic rvalid, input logic [31:0] rdata, input logic ready);
    redirect = redir; redirect_pc = rpc; imem_gnt = gnt;
    imem_rvalid = rvalid; imem_rdata = rdata; out_ready = ready;
  endtask

  initial begin
    // startup, fill to full, drain, redirect with stale response in flight
    vt[0]  = mk(0, 0, 1, 0, 0,            0, 1, 32'h0,   0, 0,     0,            0);
    vt[1]  = mk(0, 0, 0, 1, 32'h00000013, 0, 0, 32'h4,   0, 0,     0,            0);
    vt[2]  = mk(0, 0, 1, 0, 0,            0, 1, 32'h4,   1, 32'h0, 32'h00000013, 1);
    vt[3]  = mk(0, 0, 0, 1, 32'h00100093, 0, 0, 32'h8,   1, 32'h0, 32'h00000013, 1);
    vt[4]  = mk(0, 0, 1, 0, 0,            0, 1, 32'h8,   1, 32'h0, 32'h00000013, 2);
    vt[5]  = mk(0, 0, 0, 1, 32'h00200113, 0, 0, 32'hC,   1, 32'h0, 32'h00000013, 2);
    vt[6]  = mk(0, 0, 1, 0, 0,            0, 1, 32'hC,   1, 32'h0, 32'h00000013, 3);
    vt[7]  = mk(0, 0, 0, 1, 32'h00300193, 0, 0, 32'h10,  1, 32'h0, 32'h00000013, 3);
    vt[8]  = mk(0, 0, 1, 0, 0,            0, 0, 32'h10,  1, 32'h0, 32'h00000013, 4);
    vt[9]  = mk(0, 0, 1, 0, 0,            1, 0, 32'h10,  1, 32'h0, 32'h00000013, 4);
    vt[10] = mk(0, 0, 1, 0, 0,            1, 1, 32'h10,  1, 32'h4, 32'h00100093, 3);
    vt[11] = mk(0, 0, 0, 1, 32'h00400213, 1, 0, 32'h14,  1, 32'h8, 32'h00200113, 2);
    vt[12] = mk(0, 0, 0, 0, 0,            1, 1, 32'h14,  1, 32'hC, 32'h00300193, 2);
    vt[13] = mk(0, 0, 1, 0, 0,            1, 1, 32'h14,  1, 32'h10, 32'h00400213, 1);
    vt[14] = mk(1, 32'h100, 0, 0, 0,      0, 0, 32'h18,  0, 0,     0,            0);
    vt[15] = mk(0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h100, 0, 0,     0,            0);
    vt[16] = mk(0, 0, 1, 0, 0,            0, 1, 32'h100, 0, 0,     0,            0);
    vt[17] = mk(0, 0, 0, 1, 32'h11111111, 0, 0, 32'h104, 0, 0,     0,            0);
    vt[18] = mk(0, 0, 1, 0, 0,            0, 1, 32'h104, 1, 32'h100, 32'h11111111, 1);
    // misaligned redirect colliding with pop and response
    vt[19] = mk(1, 32'h203, 0, 1, 32'h22222222, 1, 0, 32'h108, 0, 0, 0,          1);
    // redirect to top of address space; grant in the redirect cycle is ignored
    vt[20] = mk(1, 32'hFFFFFFFC, 1, 1, 32'h99999999, 0, 0, 32'h200, 0, 0, 0,     0);
    vt[21] = mk(0, 0, 1, 0, 0,            0, 1, 32'hFFFFFFFC, 0, 0, 0,          0);
    vt[22] = mk(0, 0, 0, 1, 32'h33333333, 0, 0, 32'h0,   0, 0,     0,            0);
    vt[23] = mk(0, 0, 1, 0, 0,            0, 1, 32'h0,   1, 32'hFFFFFFFC, 32'h33333333, 1);
    vt[24] = mk(0, 0, 0, 1, 32'h44444444, 0, 0, 32'h4,   1, 32'hFFFFFFFC, 32'h33333333, 1);
    vt[25] = mk(0, 0, 1, 0, 0,            0, 1, 32'h4,   1, 32'hFFFFFFFC, 32'h33333333, 2);
    vt[26] = mk(0, 0, 0, 1, 32'h55555555, 0, 0, 32'h8,   1, 32'hFFFFFFFC, 32'h33333333, 2);
    vt[27] = mk(0, 0, 1, 0, 0,            0, 1, 32'h8,   1, 32'hFFFFFFFC, 32'h33333333, 3);

    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   -1, 32'(imem_req),  32'h0);
    chk("rst_addr",  -1, imem_addr,      32'h0);
    chk("rst_valid", -1, 32'(out_valid), 32'h0);
    chk("rst_count", -1, 32'(count),     32'h0);
    chk("rst_instr", -1, out_instr,      32'h0);
    chk("rst_pc",    -1, out_pc,         32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].redir, vt[i].rpc, vt[i].gnt, vt[i].rvalid, vt[i].rdata, vt[i].ready);
      #1;
      chk("req",   i, 32'(imem_req),  32'(vt[i].e_req));
      chk("addr",  i, imem_addr,      vt[i].e_addr);
      chk("valid", i, 32'(out_valid), 32'(vt[i].e_valid));
      chk("count", i, 32'(count),     32'(vt[i].e_count));
      if (vt[i].e_valid) begin
        chk("instr", i, out_instr, vt[i].e_instr);
        chk("pc",    i, out_pc,    vt[i].e_pc);
        chk("pc_4",  i, out_pc_4,  vt[i].e_pc + 32'd4);
      end
      @(negedge clk);
    end

    // Async reset with count=3 and a request outstanding: no clock edge needed
    drive(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 100, 32'(out_valid), 32'h0);
    chk("arst_req",   100, 32'(imem_req),  32'h0);
    chk("arst_count", 100, 32'(count),     32'h0);
    chk("arst_addr",  100, imem_addr,      32'h0);
    drive(0, 0, 0, 1, 32'h66666666, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_req",  101, 32'(imem_req), 32'h1);
    chk("rel_addr", 101, imem_addr,     32'h0);
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 0);
    #1;
    chk("late_count", 102, 32'(count),     32'h0);
    chk("late_valid", 102, 32'(out_valid), 32'h0);
    chk("late_req",   102, 32'(imem_req),  32'h1);
    chk("late_addr",  102, imem_addr,      32'h0);
    @(negedge clk);
    drive(0, 0, 0, 1, 32'h77777777, 0);
    #1;
    chk("re_addr", 103, imem_addr, 32'h4);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("re_valid", 104, 32'(out_valid), 32'h1);
    chk("re_pc",    104, out_pc,         32'h0);
    chk("re_instr", 104, out_instr,      32'h77777777);
    chk("re_count", 104, 32'(count),     32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
